// File: rtl/rom_download_loader_if.sv
// Host ioctl download bus between the file loader host and the ROM loader.
// Latency: none, wires only.
// Backpressure: ioctl_wait runs from the loader back to the host.
interface rom_download_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait
  );
endinterface

// File: rtl/rom_download_loader.sv
// Maps host ROM download bytes to SDRAM pages, buffers them and commits them on ce_ref slots.
// Latency: a byte entering an empty buffer raises mem_wr one cycle later; one ce_ref per bank copy.
// Backpressure: ioctl_wait once the buffer reaches FIFO_DEPTH-1 entries; bytes arriving when full are dropped and flagged.
module rom_download_loader #(
  parameter int ADDR_W     = 23,
  parameter int BANKS      = 2,
  parameter int SLOTS      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_BITS   = 256
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic                 ce_ref_i,
  rom_download_loader_if.slave ioctl,
  input  logic [SLOTS*9-1:0]   slot_page_i,
  input  logic [8:0]           exp_page_i,
  output logic                 mem_wr_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [1:0]           mem_bank_o,
  output logic [7:0]           mem_din_o,
  output logic [MAP_BITS-1:0]  rom_map_o,
  output logic                 load_done_o,
  output logic                 plus_loaded_o,
  output logic                 overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_C   = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [3:0]       ALL_MASK = 4'((1 << BANKS) - 1);

  typedef enum logic [1:0] {CL_NONE, CL_SYS, CL_EXP, CL_CART} cls_t;
  typedef enum logic       {D_IDLE, D_WRITE} drain_t;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_FLUSH} comp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [7:0]        data;
  } entry_t;

  function automatic cls_t classify(input logic [7:0] idx);
    if (idx == 8'd0)                              return CL_SYS;
    else if (idx[4:0] >= 5'd1 && idx[4:0] <= 5'd3) return CL_EXP;
    else if (idx == 8'd5 || idx == 8'd6)          return CL_CART;
    else                                          return CL_NONE;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  // Download tracking state
  logic        dl_q;
  cls_t        cls_q;
  logic [8:0]  exp_q;
  logic        ovf_q, plus_q, done_q;
  comp_t       cmp_q;

  // Write buffer
  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q, rd_nxt;
  logic [CNT_W-1:0] cnt_q;

  // Drain side
  drain_t            drn_q;
  logic              mem_wr_q, first_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        bank_q;
  logic [7:0]        din_q;
  logic [3:0]        rem_q;
  logic [MAP_BITS-1:0] rom_map_q;

  logic       rise, fall;
  cls_t       cls_eff;
  logic [8:0] exp_eff, page_d;
  logic       page_ok, wr_ok, push, drop, commit, pop, next_avail;
  logic [10:0] chunk;
  logic [22:0] full_addr;
  entry_t     push_ent, next_ent, ld_ent;
  logic [1:0] ld_bank, rem_bank;
  logic [3:0] ld_rem, rem_left;

  assign rise = ioctl.ioctl_download & ~dl_q;
  assign fall = ~ioctl.ioctl_download & dl_q;

  // Page mapping and buffer admission for the incoming host byte
  always_comb begin
    cls_eff   = rise ? classify(ioctl.ioctl_index) : cls_q;
    exp_eff   = rise ? exp_page_i : exp_q;
    chunk     = ioctl.ioctl_addr[24:14];
    page_d    = 9'd0;
    page_ok   = 1'b0;
    case (cls_eff)
      CL_SYS: begin
        for (int k = 0; k < SLOTS; k++) begin
          if (chunk == 11'(k)) begin
            page_d  = slot_page_i[9*k +: 9];
            page_ok = 1'b1;
          end
        end
      end
      CL_EXP: begin
        page_d  = exp_eff + {1'b0, ioctl.ioctl_addr[21:14]};
        page_ok = 1'b1;
      end
      CL_CART: begin
        page_d  = {1'b1, ioctl.ioctl_addr[21:14]};
        page_ok = 1'b1;
      end
      default: ;
    endcase
    full_addr     = {page_d, ioctl.ioctl_addr[13:0]};
    push_ent.addr = ADDR_W'(full_addr);
    push_ent.data = ioctl.ioctl_dout;
    push_ent.mask = (cls_eff == CL_EXP &&
                     (ioctl.ioctl_index[7:6] == 2'b01 || ioctl.ioctl_index[5:0] != 6'd0))
                    ? ALL_MASK : 4'b0001;
    wr_ok = ioctl.ioctl_wr && page_ok;
    push  = wr_ok && (cnt_q != DEPTH_C);
    drop  = wr_ok && (cnt_q == DEPTH_C);
  end

  assign ioctl.ioctl_wait = (cnt_q >= WAIT_C);

  // Commit decode and selection of the entry to present next
  always_comb begin
    rd_nxt     = rd_q + PTR_W'(1);
    commit     = mem_wr_q && ce_ref_i;
    pop        = commit && (rem_q == 4'd0);
    next_avail = (cnt_q > CNT_W'(1)) || push;
    next_ent   = (cnt_q > CNT_W'(1)) ? fifo_q[rd_nxt] : push_ent;
    ld_ent     = (drn_q == D_IDLE) ? fifo_q[rd_q] : next_ent;
    ld_bank    = lowest(ld_ent.mask);
    ld_rem     = ld_ent.mask & ~(4'b0001 << ld_bank);
    rem_bank   = lowest(rem_q);
    rem_left   = rem_q & ~(4'b0001 << rem_bank);
  end

  // Buffer storage; contents are only meaningful below the count
  always_ff @(posedge clk_48) begin
    if (push) fifo_q[wr_q] <= push_ent;
  end

  // Buffer pointers and occupancy; a push and a pop together keep the count
  always_ff @(posedge clk_48) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_nxt;
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Drain FSM: present head entry, step through banks on each ce_ref commit
  always_ff @(posedge clk_48) begin
    if (reset) begin
      drn_q     <= D_IDLE;
      mem_wr_q  <= 1'b0;
      first_q   <= 1'b0;
      addr_q    <= '0;
      bank_q    <= 2'd0;
      din_q     <= 8'd0;
      rem_q     <= 4'd0;
      rom_map_q <= '0;
    end else begin
      case (drn_q)
        D_IDLE: begin
          if (cnt_q != '0) begin
            addr_q   <= ld_ent.addr;
            din_q    <= ld_ent.data;
            bank_q   <= ld_bank;
            rem_q    <= ld_rem;
            first_q  <= 1'b1;
            mem_wr_q <= 1'b1;
            drn_q    <= D_WRITE;
          end
        end
        D_WRITE: begin
          if (commit) begin
            first_q <= 1'b0;
            if (first_q && addr_q[22]) rom_map_q[addr_q[21:14]] <= 1'b1;
            if (rem_q != 4'd0) begin
              bank_q <= rem_bank;
              rem_q  <= rem_left;
            end else if (next_avail) begin
              addr_q  <= ld_ent.addr;
              din_q   <= ld_ent.data;
              bank_q  <= ld_bank;
              rem_q   <= ld_rem;
              first_q <= 1'b1;
            end else begin
              mem_wr_q <= 1'b0;
              drn_q    <= D_IDLE;
            end
          end
        end
        default: drn_q <= D_IDLE;
      endcase
    end
  end

  // Download lifecycle: latch class on start, flush after end, report completion
  always_ff @(posedge clk_48) begin
    if (reset) begin
      dl_q   <= 1'b0;
      cls_q  <= CL_NONE;
      exp_q  <= 9'd0;
      ovf_q  <= 1'b0;
      plus_q <= 1'b0;
      done_q <= 1'b0;
      cmp_q  <= C_IDLE;
    end else begin
      dl_q   <= ioctl.ioctl_download;
      done_q <= 1'b0;
      if (rise) begin
        cls_q  <= classify(ioctl.ioctl_index);
        exp_q  <= exp_page_i;
        ovf_q  <= 1'b0;
        if (classify(ioctl.ioctl_index) == CL_CART) plus_q <= 1'b0;
        cmp_q  <= C_LOAD;
      end else begin
        case (cmp_q)
          C_LOAD:  if (fall) cmp_q <= (cls_q != CL_NONE) ? C_FLUSH : C_IDLE;
          C_FLUSH: begin
            if (cnt_q == '0 && !mem_wr_q && !push) begin
              done_q <= 1'b1;
              if (cls_q == CL_CART && !ovf_q) plus_q <= 1'b1;
              cmp_q  <= C_IDLE;
            end
          end
          default: ;
        endcase
      end
      // a drop in the start cycle belongs to the new download, so it wins over the clear
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign mem_wr_o      = mem_wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_bank_o    = bank_q;
  assign mem_din_o     = din_q;
  assign rom_map_o     = rom_map_q;
  assign load_done_o   = done_q;
  assign plus_loaded_o = plus_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_rom_download_loader.sv
// Directed bench for rom_download_loader: hand-computed addresses, banks, flags and occupancy.
// Inputs change 1 ns after the rising edge; outputs are read there or on the falling edge.
// Commits and load_done pulses are logged on the falling edge ahead of the committing edge.
module tb_rom_download_loader;

  logic         clk_48 = 1'b0;
  logic         reset, ce_ref;
  logic [35:0]  slot_page;
  logic [8:0]   exp_page;
  logic         mem_wr, load_done, plus_loaded, overflow;
  logic [22:0]  mem_addr;
  logic [1:0]   mem_bank;
  logic [7:0]   mem_din;
  logic [255:0] rom_map;

  rom_download_loader_if bus();

  rom_download_loader dut (
    .clk_48       (clk_48),
    .reset        (reset),
    .ce_ref_i     (ce_ref),
    .ioctl        (bus),
    .slot_page_i  (slot_page),
    .exp_page_i   (exp_page),
    .mem_wr_o     (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_bank_o   (mem_bank),
    .mem_din_o    (mem_din),
    .rom_map_o    (rom_map),
    .load_done_o  (load_done),
    .plus_loaded_o(plus_loaded),
    .overflow_o   (overflow)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  b;
    logic [7:0]  d;
  } cm_t;

  cm_t commits[$];
  int  done_cnt = 0;
  int  done_commits = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_timeout = 0;

  always @(negedge clk_48) begin
    if (mem_wr && ce_ref) commits.push_back({mem_addr, mem_bank, mem_din});
    if (load_done) begin
      done_cnt     <= done_cnt + 1;
      done_commits <= commits.size();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic host_byte(input logic [24:0] a, input logic [7:0] d);
    for (int i = 0; i < 50 && bus.ioctl_wait; i++) tick();
    if (bus.ioctl_wait) n_timeout++;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({mem_wr, load_done, plus_loaded, overflow, bus.ioctl_wait} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {mem_wr, load_done, plus_loaded, overflow, bus.ioctl_wait});
    end
    n_chk++;
    if ({mem_addr, mem_bank, mem_din} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_bank, mem_din});
    end
    n_chk++;
    if (rom_map !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_rom_map: got %h want 0", rom_map);
    end
    n_chk++;
    if (dut.cnt_q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", dut.cnt_q);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sys();
    cm_t exp_c[4];
    cm_t got;
    logic [255:0] exp_map;
    int d0;
    exp_c[0] = '{a: 23'h000003, b: 2'd0, d: 8'h11};
    exp_c[1] = '{a: 23'h400010, b: 2'd0, d: 8'h22};
    exp_c[2] = '{a: 23'h41C005, b: 2'd0, d: 8'h33};
    exp_c[3] = '{a: 23'h3FC000, b: 2'd0, d: 8'h44};
    slot_page = {9'h0FF, 9'h107, 9'h100, 9'h000};
    ce_ref = 1'b1;
    commits.delete();
    d0 = done_cnt;
    begin_dl(8'h00);
    host_byte(25'h0000003, 8'h11);
    host_byte(25'h0004010, 8'h22);
    host_byte(25'h0008005, 8'h33);
    host_byte(25'h000C000, 8'h44);
    repeat (6) tick();
    n_chk++;
    if (commits.size() !== 4) begin
      n_fail++;
      $display("FAIL sys_commit_count: got %0d want 4", commits.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < commits.size()) ? commits[i] : '1;
      n_chk++;
      if (got !== exp_c[i]) begin
        n_fail++;
        $display("FAIL sys_commit%0d: got %h want %h", i, got, exp_c[i]);
      end
    end
    // chunk 4 lies beyond SLOTS: silently ignored
    host_byte(25'h0010000, 8'h55);
    repeat (5) tick();
    n_chk++;
    if (commits.size() !== 4 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL sys_range_drop: got commits=%0d mem_wr=%b want 4 0", commits.size(), mem_wr);
    end
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sys_range_overflow: got %b want 0", overflow);
    end
    end_dl();
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    n_chk++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL sys_load_done_pulses: got %0d want 1", done_cnt - d0);
    end
    n_chk++;
    if (done_commits !== 4) begin
      n_fail++;
      $display("FAIL sys_done_after_commits: got %0d want 4", done_commits);
    end
    exp_map = '0;
    exp_map[8'h00] = 1'b1;
    exp_map[8'h07] = 1'b1;
    n_chk++;
    if (rom_map !== exp_map) begin
      n_fail++;
      $display("FAIL sys_rom_map: got %h want %h", rom_map, exp_map);
    end
  endtask

  task automatic test_exp();
    cm_t exp_c[2];
    cm_t got;
    logic [255:0] exp_map;
    int d0;
    exp_c[0] = '{a: 23'h7C4000, b: 2'd0, d: 8'h5A};
    exp_c[1] = '{a: 23'h7C4000, b: 2'd1, d: 8'h5A};
    ce_ref = 1'b1;
    exp_page = 9'h1F0;
    commits.delete();
    d0 = done_cnt;
    begin_dl(8'h41);
    exp_page = 9'h000;
    host_byte(25'h0004000, 8'h5A);
    n_chk++;
    if (mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_latency_early: got mem_wr=%b want 0", mem_wr);
    end
    tick();
    n_chk++;
    if ({mem_wr, mem_bank, mem_addr} !== {1'b1, 2'd0, 23'h7C4000}) begin
      n_fail++;
      $display("FAIL exp_first_present: got %h want %h", {mem_wr, mem_bank, mem_addr}, {1'b1, 2'd0, 23'h7C4000});
    end
    repeat (4) tick();
    n_chk++;
    if (commits.size() !== 2) begin
      n_fail++;
      $display("FAIL exp_commit_count: got %0d want 2", commits.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < commits.size()) ? commits[i] : '1;
      n_chk++;
      if (got !== exp_c[i]) begin
        n_fail++;
        $display("FAIL exp_commit%0d: got %h want %h", i, got, exp_c[i]);
      end
    end
    end_dl();
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    n_chk++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL exp_load_done: got %0d want 1", done_cnt - d0);
    end
    exp_map = '0;
    exp_map[8'h00] = 1'b1;
    exp_map[8'h07] = 1'b1;
    exp_map[8'hF1] = 1'b1;
    n_chk++;
    if (rom_map !== exp_map) begin
      n_fail++;
      $display("FAIL exp_rom_map: got %h want %h", rom_map, exp_map);
    end
  endtask

  task automatic test_cart_honour();
    cm_t got, want;
    int sent, d0;
    bit saw;
    sent = 0;
    saw = 1'b0;
    ce_ref = 1'b0;
    commits.delete();
    d0 = done_cnt;
    begin_dl(8'h05);
    for (int c = 0; c < 400; c++) begin
      ce_ref = (c % 8 == 7);
      if (sent < 6 && !bus.ioctl_wait) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(16 + sent);
        bus.ioctl_dout = 8'(8'hA0 + sent);
        sent++;
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      tick();
      n_chk++;
      if (bus.ioctl_wait !== (dut.cnt_q >= 3'd3)) begin
        n_fail++;
        $display("FAIL cart_wait_rule: got wait=%b at count %0d", bus.ioctl_wait, dut.cnt_q);
      end
      if (dut.cnt_q >= 3'd3) saw = 1'b1;
      if (sent == 6 && dut.cnt_q == 3'd0 && !mem_wr) break;
    end
    bus.ioctl_wr = 1'b0;
    ce_ref = 1'b1;
    n_chk++;
    if (saw !== 1'b1) begin
      n_fail++;
      $display("FAIL cart_wait_seen: got %b want 1", saw);
    end
    n_chk++;
    if (commits.size() !== 6) begin
      n_fail++;
      $display("FAIL cart_commit_count: got %0d want 6", commits.size());
    end
    for (int i = 0; i < 6; i++) begin
      got  = (i < commits.size()) ? commits[i] : '1;
      want = '{a: 23'(23'h400010 + i), b: 2'd0, d: 8'(8'hA0 + i)};
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cart_commit%0d: got %h want %h", i, got, want);
      end
    end
    end_dl();
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    n_chk++;
    if ({done_cnt == d0 + 1, plus_loaded, overflow} !== 3'b110) begin
      n_fail++;
      $display("FAIL cart_plus_loaded: got done/plus/ovf=%b want 110", {done_cnt == d0 + 1, plus_loaded, overflow});
    end
  endtask

  task automatic test_cart_ignore();
    int exp_cnt[5] = '{1, 2, 3, 4, 4};
    bit exp_wait[5] = '{0, 0, 1, 1, 1};
    bit exp_ovf[5]  = '{0, 0, 0, 0, 1};
    cm_t want;
    int d0;
    ce_ref = 1'b0;
    commits.delete();
    d0 = done_cnt;
    begin_dl(8'h05);
    n_chk++;
    if (plus_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL cart_start_clears_plus: got %b want 0", plus_loaded);
    end
    for (int i = 0; i < 5; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(32 + i);
      bus.ioctl_dout = 8'(8'hC0 + i);
      tick();
      n_chk++;
      if ({32'(dut.cnt_q), bus.ioctl_wait, overflow} !== {32'(exp_cnt[i]), exp_wait[i], exp_ovf[i]}) begin
        n_fail++;
        $display("FAIL cart_ignore_step%0d: got cnt=%0d wait=%b ovf=%b want cnt=%0d wait=%b ovf=%b",
                 i, dut.cnt_q, bus.ioctl_wait, overflow, exp_cnt[i], exp_wait[i], exp_ovf[i]);
      end
    end
    bus.ioctl_wr = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ce_ref = (c % 8 == 7);
      tick();
      if (dut.cnt_q == 3'd0 && !mem_wr) break;
    end
    ce_ref = 1'b1;
    end_dl();
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    n_chk++;
    if ({done_cnt == d0 + 1, plus_loaded, overflow} !== 3'b101) begin
      n_fail++;
      $display("FAIL cart_overflow_no_plus: got done/plus/ovf=%b want 101", {done_cnt == d0 + 1, plus_loaded, overflow});
    end
    want = '{a: 23'h400023, b: 2'd0, d: 8'hC3};
    n_chk++;
    if (commits.size() !== 4 || commits[commits.size() - 1] !== want) begin
      n_fail++;
      $display("FAIL cart_ignore_commits: got n=%0d last=%h want n=4 last=%h",
               commits.size(), (commits.size() > 0) ? commits[commits.size() - 1] : '1, want);
    end
  endtask

  task automatic test_back_to_back();
    cm_t got, want;
    int d0;
    ce_ref = 1'b0;
    commits.delete();
    d0 = done_cnt;
    begin_dl(8'h06);
    host_byte(25'h0000030, 8'hD0);
    host_byte(25'h0000031, 8'hD1);
    n_chk++;
    if ({mem_wr, dut.cnt_q} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL b2b_setup: got wr=%b cnt=%0d want wr=1 cnt=2", mem_wr, dut.cnt_q);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h0000032;
    bus.ioctl_dout = 8'hD2;
    ce_ref = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    n_chk++;
    if (dut.cnt_q !== 3'd2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", dut.cnt_q);
    end
    n_chk++;
    if ({mem_addr, mem_din} !== {23'h400031, 8'hD1}) begin
      n_fail++;
      $display("FAIL b2b_next_entry: got %h want %h", {mem_addr, mem_din}, {23'h400031, 8'hD1});
    end
    repeat (4) tick();
    end_dl();
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    n_chk++;
    if (commits.size() !== 3) begin
      n_fail++;
      $display("FAIL b2b_commit_count: got %0d want 3", commits.size());
    end
    for (int i = 0; i < 3; i++) begin
      got  = (i < commits.size()) ? commits[i] : '1;
      want = '{a: 23'(23'h400030 + i), b: 2'd0, d: 8'(8'hD0 + i)};
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_order%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    ce_ref = 1'b0;
    commits.delete();
    begin_dl(8'h05);
    host_byte(25'h0000040, 8'hE0);
    host_byte(25'h0000041, 8'hE1);
    host_byte(25'h0000042, 8'hE2);
    n_chk++;
    if ({mem_wr, dut.cnt_q} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got wr=%b cnt=%0d want wr=1 cnt=3", mem_wr, dut.cnt_q);
    end
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if ({mem_wr, dut.cnt_q, bus.ioctl_wait, plus_loaded} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got wr=%b cnt=%0d wait=%b plus=%b want 0 0 0 0",
               mem_wr, dut.cnt_q, bus.ioctl_wait, plus_loaded);
    end
    d0 = done_cnt;
    reset = 1'b0;
    ce_ref = 1'b1;
    repeat (20) tick();
    n_chk++;
    if (commits.size() !== 0 || done_cnt !== d0 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got commits=%0d done=%0d wr=%b want 0 0 0",
               commits.size(), done_cnt - d0, mem_wr);
    end
  endtask

  task automatic test_host_waits();
    n_chk++;
    if (n_timeout !== 0) begin
      n_fail++;
      $display("FAIL host_wait_timeouts: got %0d want 0", n_timeout);
    end
  endtask

  initial begin
    reset              = 1'b1;
    ce_ref             = 1'b0;
    slot_page          = '0;
    exp_page           = '0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    test_reset();
    test_sys();
    test_exp();
    test_cart_honour();
    test_cart_ignore();
    test_back_to_back();
    test_reset_mid();
    test_host_waits();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
